// File: rtl/pifo_pkg.sv
// Shared constants for the PIFO rank queue: default sizing and entry field layout.
// Entries are packed as {queue, priority, pkt_length} with pkt_length in the low bits.
package pifo_pkg;

  localparam int DEF_DEPTH              = 16;
  localparam int DEF_QUEUE_COUNT        = 64;
  localparam int DEF_QUEUE_INDEX_WIDTH  = 6;
  localparam int DEF_PER_PRIORITY_WIDTH = 3;
  localparam int DEF_PACKET_WIDTH       = 7;
  localparam int ENTRY_WIDTH = DEF_QUEUE_INDEX_WIDTH + DEF_PER_PRIORITY_WIDTH + DEF_PACKET_WIDTH;

  function automatic int prio_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int queue_lsb(input int prio_w, input int len_w);
    return prio_w + len_w;
  endfunction

endpackage

// File: rtl/pifo_cell.sv
// One PIFO slot: holds an entry plus valid bit, loads from the new entry or a neighbour,
// and flags whether its rank is strictly greater than the incoming rank.
module pifo_cell
  import pifo_pkg::*;
#(
  parameter int QW = DEF_QUEUE_INDEX_WIDTH,
  parameter int PW = DEF_PER_PRIORITY_WIDTH,
  parameter int LW = DEF_PACKET_WIDTH,
  localparam int EW = QW + PW + LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] left_entry,
  input  logic          left_valid,
  input  logic [EW-1:0] right_entry,
  input  logic          right_valid,
  input  logic [EW-1:0] new_entry,
  input  logic          insert_here,
  input  logic          shift_up,
  input  logic          shift_down,
  output logic [EW-1:0] entry,
  output logic          valid,
  output logic          greater_than_new
);

  localparam int PL = prio_lsb(LW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (insert_here) begin
      entry <= new_entry;
      valid <= 1'b1;
    end else if (shift_up) begin
      entry <= left_entry;
      valid <= left_valid;
    end else if (shift_down) begin
      entry <= right_entry;
      valid <= right_valid;
    end
  end

  assign greater_than_new = valid && (entry[PL +: PW] > new_entry[PL +: PW]);

endmodule

// File: rtl/pifo_rank_queue.sv
// Push-in-first-out rank queue: sorted insert by priority (FIFO among equal ranks), head pop
// with per-queue toggle signal. Optional empty-queue bypass under PIFO_EMPTY_BYPASS_EN.
module pifo_rank_queue
  import pifo_pkg::*;
#(
  parameter int DEPTH              = DEF_DEPTH,
  parameter int QUEUE_COUNT        = DEF_QUEUE_COUNT,
  parameter int QUEUE_INDEX_WIDTH  = DEF_QUEUE_INDEX_WIDTH,
  parameter int PER_PRIORITY_WIDTH = DEF_PER_PRIORITY_WIDTH,
  parameter int PACKET_WIDTH       = DEF_PACKET_WIDTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0]  s_axis_doorbell_queue,
  input  logic                          s_axis_doorbell_valid,
  input  logic [PER_PRIORITY_WIDTH-1:0] s_axis_doorbell_priority,
  input  logic [PACKET_WIDTH-1:0]       s_axis_doorbell_pkt_length,
  output logic                          s_axis_doorbell_ready,
  input  logic                          m_axis_pop_req,
  output logic                          m_axis_pop_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0]  m_axis_pop_queue,
  output logic [PER_PRIORITY_WIDTH-1:0] m_axis_pop_priority,
  output logic [PACKET_WIDTH-1:0]       m_axis_pop_pkt_length,
  output logic [QUEUE_COUNT-1:0]        pifo_pop_signal,
  output logic [CW-1:0]                 status_count
);

  localparam int QW = QUEUE_INDEX_WIDTH;
  localparam int PW = PER_PRIORITY_WIDTH;
  localparam int LW = PACKET_WIDTH;
  localparam int EW = QW + PW + LW;
  localparam int PL = prio_lsb(LW);
  localparam int QL = queue_lsb(PW, LW);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]    slot_entry [DEPTH];
  logic [EW-1:0]    left_e     [DEPTH];
  logic [EW-1:0]    right_e    [DEPTH];
  logic [DEPTH-1:0] slot_valid, slot_gt, left_v, right_v;
  logic [DEPTH-1:0] ins_here, up, down;
  logic [DEPTH:0]   cond, here;
  logic [EW-1:0]    new_entry;
  logic [CW-1:0]    count;
  logic             do_ins, do_pop, bypass, ins_store;

  assign new_entry             = {s_axis_doorbell_queue, s_axis_doorbell_priority, s_axis_doorbell_pkt_length};
  assign s_axis_doorbell_ready = (count < FULL);
  assign status_count          = count;
  assign do_ins                = s_axis_doorbell_valid && s_axis_doorbell_ready;
  assign do_pop                = m_axis_pop_req && (count != '0);

`ifdef PIFO_EMPTY_BYPASS_EN
  assign bypass = do_ins && m_axis_pop_req && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign ins_store = do_ins && !bypass;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      left_e[i]  = (i == 0) ? '0 : slot_entry[(i == 0) ? 0 : i-1];
      left_v[i]  = (i == 0) ? 1'b0 : slot_valid[(i == 0) ? 0 : i-1];
      right_e[i] = (i == DEPTH-1) ? '0 : slot_entry[(i == DEPTH-1) ? i : i+1];
      right_v[i] = (i == DEPTH-1) ? 1'b0 : slot_valid[(i == DEPTH-1) ? i : i+1];
    end
  end

  // cond is a thermometer (0s then 1s): slot i is at or past the insert point.
  // here is its one-hot edge, i.e. the insert position on the current array.
  always_comb begin
    cond = '1;
    for (int i = 0; i < DEPTH; i++)
      cond[i] = slot_gt[i] | ~slot_valid[i];
    here    = '0;
    here[0] = cond[0];
    for (int i = 1; i <= DEPTH; i++)
      here[i] = cond[i] & ~cond[i-1];
  end

  // With a concurrent pop the insert lands one slot lower (floored at 0); slots below it
  // shift down and slots above it keep their contents.
  always_comb begin
    ins_here = '0;
    up       = '0;
    down     = '0;
    if (do_pop && ins_store) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_here[i] = here[i+1] | ((i == 0) & here[0]);
        down[i]     = ~cond[i+1];
      end
    end else if (ins_store) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_here[i] = here[i];
        if (i > 0) up[i] = cond[i-1];
      end
    end else if (do_pop) begin
      down = '1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    pifo_cell #(.QW(QW), .PW(PW), .LW(LW)) u_cell (
      .clk              (clk),
      .rst              (rst),
      .left_entry       (left_e[g]),
      .left_valid       (left_v[g]),
      .right_entry      (right_e[g]),
      .right_valid      (right_v[g]),
      .new_entry        (new_entry),
      .insert_here      (ins_here[g]),
      .shift_up         (up[g]),
      .shift_down       (down[g]),
      .entry            (slot_entry[g]),
      .valid            (slot_valid[g]),
      .greater_than_new (slot_gt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count                 <= '0;
      m_axis_pop_valid      <= 1'b0;
      m_axis_pop_queue      <= '0;
      m_axis_pop_priority   <= '0;
      m_axis_pop_pkt_length <= '0;
      pifo_pop_signal       <= '0;
    end else begin
      m_axis_pop_valid <= do_pop | bypass;
      if (do_pop) begin
        m_axis_pop_queue      <= slot_entry[0][QL +: QW];
        m_axis_pop_priority   <= slot_entry[0][PL +: PW];
        m_axis_pop_pkt_length <= slot_entry[0][0 +: LW];
        pifo_pop_signal[slot_entry[0][QL +: QW]] <= ~pifo_pop_signal[slot_entry[0][QL +: QW]];
      end else if (bypass) begin
        m_axis_pop_queue      <= s_axis_doorbell_queue;
        m_axis_pop_priority   <= s_axis_doorbell_priority;
        m_axis_pop_pkt_length <= s_axis_doorbell_pkt_length;
        pifo_pop_signal[s_axis_doorbell_queue] <= ~pifo_pop_signal[s_axis_doorbell_queue];
      end
      if (ins_store && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !ins_store)
        count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Directed self-checking bench for pifo_rank_queue; expected pop order and toggle vector
// are hand-derived. Bypass expectations follow PIFO_EMPTY_BYPASS_EN.
module tb_pifo_rank_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  db_queue = '0;
  logic        db_valid = 1'b0;
  logic [2:0]  db_prio = '0;
  logic [6:0]  db_len = '0;
  logic        db_ready;
  logic        pop_req = 1'b0;
  logic        pop_valid;
  logic [5:0]  pop_queue;
  logic [2:0]  pop_prio;
  logic [6:0]  pop_len;
  logic [63:0] pop_signal;
  logic [4:0]  status_count;

  logic [63:0] exp_sig = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pifo_rank_queue dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_axis_doorbell_queue      (db_queue),
    .s_axis_doorbell_valid      (db_valid),
    .s_axis_doorbell_priority   (db_prio),
    .s_axis_doorbell_pkt_length (db_len),
    .s_axis_doorbell_ready      (db_ready),
    .m_axis_pop_req             (pop_req),
    .m_axis_pop_valid           (pop_valid),
    .m_axis_pop_queue           (pop_queue),
    .m_axis_pop_priority        (pop_prio),
    .m_axis_pop_pkt_length      (pop_len),
    .pifo_pop_signal            (pop_signal),
    .status_count               (status_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus, returns 1 time unit after the active edge.
  task automatic applyStimulus(input logic ins, input logic [5:0] q, input logic [2:0] p,
                               input logic [6:0] l, input logic pop);
    db_valid = ins;
    db_queue = q;
    db_prio  = p;
    db_len   = l;
    pop_req  = pop;
    @(posedge clk);
    #1;
    db_valid = 1'b0;
    pop_req  = 1'b0;
  endtask

  task automatic expectPop(input string tag, input logic [5:0] q, input logic [2:0] p, input logic [6:0] l);
    exp_sig[q] = ~exp_sig[q];
    checkOutput({tag, "_valid"}, 64'(pop_valid), 64'd1);
    checkOutput({tag, "_queue"}, 64'(pop_queue), 64'(q));
    checkOutput({tag, "_prio"},  64'(pop_prio),  64'(p));
    checkOutput({tag, "_len"},   64'(pop_len),   64'(l));
    checkOutput({tag, "_sig"},   pop_signal,     exp_sig);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_count", 64'(status_count), 64'd0);
    checkOutput("rst_valid", 64'(pop_valid), 64'd0);
    checkOutput("rst_sig",   pop_signal, 64'd0);
    checkOutput("rst_ready", 64'(db_ready), 64'd1);
    checkOutput("rst_queue", 64'(pop_queue), 64'd0);

    // Single insert then pop
    applyStimulus(1'b1, 6'd3, 3'd5, 7'd20, 1'b0);
    checkOutput("one_count", 64'(status_count), 64'd1);
    checkOutput("one_novalid", 64'(pop_valid), 64'd0);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("one", 6'd3, 3'd5, 7'd20);
    checkOutput("one_sig3", 64'(pop_signal[3]), 64'd1);
    checkOutput("one_count0", 64'(status_count), 64'd0);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("one_pulse", 64'(pop_valid), 64'd0);

    // Ordering with equal-rank FIFO
    applyStimulus(1'b1, 6'd10, 3'd4, 7'd1, 1'b0);
    applyStimulus(1'b1, 6'd11, 3'd1, 7'd2, 1'b0);
    applyStimulus(1'b1, 6'd12, 3'd6, 7'd3, 1'b0);
    applyStimulus(1'b1, 6'd13, 3'd1, 7'd4, 1'b0);
    checkOutput("ord_count", 64'(status_count), 64'd4);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("ord0", 6'd11, 3'd1, 7'd2);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("ord1", 6'd13, 3'd1, 7'd4);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("ord2", 6'd10, 3'd4, 7'd1);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("ord3", 6'd12, 3'd6, 7'd3);
    checkOutput("ord_empty", 64'(status_count), 64'd0);

    // Fill to capacity, refuse an extra insert, then drain with pop_req held
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 6'(i), 3'(i % 8), 7'(i + 32), 1'b0);
    checkOutput("full_count", 64'(status_count), 64'd16);
    checkOutput("full_ready", 64'(db_ready), 64'd0);
    applyStimulus(1'b1, 6'd40, 3'd0, 7'd0, 1'b0);
    checkOutput("full_reject", 64'(status_count), 64'd16);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
      expectPop($sformatf("drain%0d", k), 6'((k % 2) * 8 + k / 2), 3'(k / 2), 7'((k % 2) * 8 + k / 2 + 32));
      if (k == 0) checkOutput("full_ready_back", 64'(db_ready), 64'd1);
    end
    checkOutput("drain_count", 64'(status_count), 64'd0);

    // Concurrent insert + pop
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 6'(20 + i), 3'(2 + i), 7'(i), 1'b0);
    applyStimulus(1'b1, 6'd7, 3'd0, 7'd99, 1'b1);
    expectPop("sim_head", 6'd20, 3'd2, 7'd0);
    checkOutput("sim_count", 64'(status_count), 64'd5);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("sim_new", 6'd7, 3'd0, 7'd99);
    applyStimulus(1'b1, 6'd30, 3'd4, 7'd50, 1'b1);
    expectPop("mid_head", 6'd21, 3'd3, 7'd1);
    checkOutput("mid_count", 64'(status_count), 64'd4);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("mid0", 6'd22, 3'd4, 7'd2);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("mid1", 6'd30, 3'd4, 7'd50);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("mid2", 6'd23, 3'd5, 7'd3);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("mid3", 6'd24, 3'd6, 7'd4);

    // Pop on empty, then pop coinciding with an insert on empty
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    checkOutput("empty_valid", 64'(pop_valid), 64'd0);
    checkOutput("empty_sig", pop_signal, exp_sig);
    applyStimulus(1'b1, 6'd9, 3'd2, 7'd17, 1'b1);
`ifdef PIFO_EMPTY_BYPASS_EN
    expectPop("bypass", 6'd9, 3'd2, 7'd17);
    checkOutput("bypass_count", 64'(status_count), 64'd0);
`else
    checkOutput("nobypass_valid", 64'(pop_valid), 64'd0);
    checkOutput("nobypass_count", 64'(status_count), 64'd1);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("nobypass_pop", 6'd9, 3'd2, 7'd17);
`endif

    // Asynchronous reset mid-burst
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 6'(40 + i), 3'(i % 4), 7'(i), 1'b0);
    checkOutput("burst_count", 64'(status_count), 64'd8);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("burst_pop", 6'd40, 3'd0, 7'd0);
    #2 rst = 1'b1;
    #1;
    exp_sig = '0;
    checkOutput("arst_count", 64'(status_count), 64'd0);
    checkOutput("arst_valid", 64'(pop_valid), 64'd0);
    checkOutput("arst_queue", 64'(pop_queue), 64'd0);
    checkOutput("arst_sig", pop_signal, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("arst_ready", 64'(db_ready), 64'd1);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    checkOutput("arst_nopop", 64'(pop_valid), 64'd0);
    applyStimulus(1'b1, 6'd5, 3'd3, 7'd8, 1'b0);
    applyStimulus(1'b0, 6'd0, 3'd0, 7'd0, 1'b1);
    expectPop("recover", 6'd5, 3'd3, 7'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pifo_rank_queue.md
Name: pifo_rank_queue

Overview:
Push-in-first-out rank queue that consumes the arbitrated doorbell stream leaving the per-queue metadata store. It holds up to DEPTH entries of {queue, priority, pkt_length} in ascending-priority order. It pops the lowest-rank entry to the transmit scheduler on request. On every pop it toggles that entry's bit in a per-queue pop-signal vector, which releases the queue's in-PIFO tag upstream.

Parameters:
- DEPTH, 16: entry slots; power of 2, at least 2.
- QUEUE_COUNT, 64: number of queues; must equal 2**QUEUE_INDEX_WIDTH.
- QUEUE_INDEX_WIDTH, 6: width of the queue index.
- PER_PRIORITY_WIDTH, 3: rank width; lower value = higher priority.
- PACKET_WIDTH, 7: packet-length field width.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- s_axis_doorbell_queue  in  QUEUE_INDEX_WIDTH: queue index of the inserted entry.
- s_axis_doorbell_valid  in  1: insert request.
- s_axis_doorbell_priority  in  PER_PRIORITY_WIDTH: rank of the inserted entry.
- s_axis_doorbell_pkt_length  in  PACKET_WIDTH: packet length of the inserted entry.
- s_axis_doorbell_ready  out  1: space available.
- m_axis_pop_req  in  1: scheduler dequeue request.
- m_axis_pop_valid  out  1: one-cycle pulse; pop result is valid.
- m_axis_pop_queue  out  QUEUE_INDEX_WIDTH: queue index of the popped entry.
- m_axis_pop_priority  out  PER_PRIORITY_WIDTH: rank of the popped entry.
- m_axis_pop_pkt_length  out  PACKET_WIDTH: packet length of the popped entry.
- pifo_pop_signal  out  QUEUE_COUNT: per-queue toggle, one toggle per pop.
- status_count  out  $clog2(DEPTH)+1: current occupancy.

Behaviour:
- Reset, asynchronous, all registers cleared:
  - count = 0; all slots invalid.
  - m_axis_pop_valid = 0; pop data outputs = 0.
  - pifo_pop_signal = 0.
  - s_axis_doorbell_ready = 1 once rst deasserts.
  - An in-flight pop or insert is discarded.
- Storage:
  - Slot array in which slot 0 is the head (lowest rank).
  - Each slot holds a valid bit plus entry fields.
  - Valid slots are always contiguous from slot 0.
- Ready: s_axis_doorbell_ready = (count < DEPTH), driven combinationally from the count register.
- Insert, when valid && ready:
  - The new entry is placed at the first slot whose priority is strictly greater than the new priority, or at the first empty slot.
  - Slots from that point onward shift up by one.
  - Equal ranks therefore stay FIFO.
  - count increments at that edge.
- Pop, when m_axis_pop_req && count > 0:
  - At the same edge, slot 0 is registered onto m_axis_pop_*, m_axis_pop_valid = 1 for exactly one cycle, and pifo_pop_signal[slot0.queue] inverts.
  - The array shifts down by one and count decrements.
  - Latency from req to valid is 1 cycle.
- pop_req with count == 0: ignored; no valid pulse, no toggle.
- Simultaneous insert and pop in the same cycle:
  - Both take effect.
  - The old head is popped.
  - The new entry is inserted relative to the post-shift array, so its slot index is (computed position − 1), floored at 0.
  - count is unchanged.
- Insert with priority below the head's while popping: the new entry becomes the head after the edge; the old head is still the one popped.
- Full (count == DEPTH) with a pop: ready is still low that cycle, so no insert happens; ready rises the next cycle.
- pop_req held high: one pop per cycle until empty.
- Two pops of the same queue in consecutive cycles: that queue's bit toggles twice, back to its original value. Upstream samples every cycle.

Optional Feature:
- Macro: PIFO_EMPTY_BYPASS_EN.
- Defined: when count == 0 and insert and pop_req coincide, the incoming entry goes straight to m_axis_pop_* next cycle with valid = 1 and a toggle; it is never stored and count stays 0.
- Undefined: pop_req on an empty queue is ignored and the insert is stored normally, so count becomes 1.

Decomposition:
- Shared package pifo_pkg holds the entry field offsets/widths (ENTRY_WIDTH = QUEUE_INDEX_WIDTH + PER_PRIORITY_WIDTH + PACKET_WIDTH) and the default parameter constants.
- Natural sub-module: pifo_cell, one slot.
  - Inputs: left and right neighbour entries, the new entry, insert_here/shift_up/shift_down controls.
  - Output: greater_than_new compare flag.
  - The top level does the thermometer-to-position logic.

Test Plan:
- Reset, then insert queue=3/prio=5 → next cycle status_count=1. Pop → valid=1, queue=3, prio=5; pifo_pop_signal[3] goes 0→1.
- Insert prios 4, 1, 6, 1 on queues 10, 11, 12, 13, then 4 pops → pop order is queues 11, 13, 10, 12 (equal-rank FIFO).
- Fill 16 entries → ready=0. Insert attempt with valid=1 → no change, count=16. Pop → ready=1 the next cycle.
- Hold 5 entries, insert prio=0 queue=7 with a simultaneous pop → old head popped, count stays 5, and the next pop returns queue=7.
- pop_req with the array empty → no valid pulse, pifo_pop_signal unchanged. With PIFO_EMPTY_BYPASS_EN and a concurrent insert of queue=9 → valid next cycle with queue=9, bit 9 toggles, count=0.
- Assert rst asynchronously mid-burst with count=8 → outputs clear immediately, count=0, and later pops produce no output until new inserts arrive.
